fantasticfft_fftn: RTL and testbench
====================================

Name: fantasticfft_fftn

Overview:
- Parametrised successor to the fixed 8-point FFT core: an iterative, in-place, radix-2 decimation-in-time FFT.
- Supports any power-of-two point count N, configurable fixed-point sample width and optional per-stage scaling.
- Streams one frame in (natural order), computes with a single time-shared butterfly, then streams the spectrum out (natural bin order).
- Sits between the sample front-end and the spectral post-processing in the fantasticfft datapath.

Parameters:
- N, 8: points per frame; power of two, 8..256.
- WIDTH, 16: signed bits per real/imag component.
- FRAC, 8: fractional bits of samples (Q(WIDTH-FRAC).FRAC, same convention as the fixed-point macros).
- TW_WIDTH, 16: signed twiddle width; 1.0 = 2^(TW_WIDTH-2). Table built at elaboration from cos/sin.
- SCALE, 1: 1 = arithmetic shift right by 1 after every stage; 0 = no scaling, saturate instead.

Ports:
- clk  in  1  clock, all logic rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input sample valid.
- in_ready  out  1  core accepts a sample this cycle.
- in_re  in  WIDTH  input real, signed.
- in_im  in  WIDTH  input imag, signed.
- out_valid  out  1  output bin valid.
- out_ready  in  1  downstream accepts bin.
- out_re  out  WIDTH  bin real.
- out_im  out  WIDTH  bin imag.
- out_last  out  1  high with bin N-1.
- busy  out  1  high in COMPUTE or UNLOAD.

Behaviour:
- Reset (async assert, sync deassert inside core):
  - state = LOAD; all counters = 0.
  - in_ready = 1, out_valid = 0, out_last = 0, busy = 0, out_re/out_im = 0.
  - Sample memory contents are don't-care.
- States: LOAD -> COMPUTE -> UNLOAD -> LOAD. There is no frame overlap.
- LOAD:
  - in_ready = 1.
  - Each in_valid & in_ready cycle writes sample n to address bitrev(n) and increments n.
  - After sample N-1 is accepted, the next cycle is COMPUTE.
- COMPUTE:
  - in_ready = 0, busy = 1.
  - Runs log2(N) stages of N/2 butterflies, one butterfly per cycle; total exactly log2(N)*N/2 cycles, then UNLOAD.
  - Stage s (0-based) pairs addresses a, a + 2^s, using twiddle W^k with k = (j mod 2^s) * N/2^(s+1).
  - Butterfly: t = B*W; A' = A + t; B' = A - t.
  - Reads are combinational from the register array; writes land at the cycle end.
- Arithmetic:
  - Complex multiply uses full-precision products, summed, then arithmetic right shift by TW_WIDTH-2 (truncation toward -inf).
  - Add/sub computed in WIDTH+1 bits.
  - SCALE=1: result >>>1 (truncate) back to WIDTH, so the overall result is X[k]/N.
  - SCALE=0: result saturated to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
  - W^0 = exactly 1.0, so it is lossless.
- UNLOAD:
  - busy = 1; bin k = 0..N-1 presented in natural order from address k.
  - out_valid = 1; out_re/out_im/out_last stay stable while out_ready = 0.
  - Advance only on out_valid & out_ready.
  - After bin N-1 is transferred: out_valid = 0 and the next cycle is LOAD, with in_ready = 1.
- Boundary conditions:
  - in_valid while in_ready = 0 is ignored; no sample is consumed.
  - Stalled input in LOAD simply waits; there is no timeout.
  - out_ready may toggle arbitrarily; no bin is dropped or duplicated.
  - rst_n asserted in any state aborts the frame immediately and returns to the reset values above; a partial frame is discarded.
  - in_valid & in_ready on the same edge as the last out transfer cannot occur; the states are exclusive.

Test Plan:
- N=8, WIDTH=16, FRAC=8, SCALE=1; impulse x[0]=0x0100, rest 0 -> all 8 bins re=0x0020, im=0x0000, exact; out_last only on bin 7.
- Same config, DC x[n]=0x0100 -> bin0 re=0x0100, im=0; bins 1..7 = 0 within +/-1 LSB.
- Same config, alternating x[n]=+/-0x0100 (x[0] positive) -> bin4 re=0x0100, others 0 within +/-1 LSB.
  - Check timing: COMPUTE lasts exactly 12 cycles (busy high from the cycle after sample 7 to first out_valid).
- Backpressure, impulse frame: hold out_ready=0 for 5 cycles at bin 3 -> out_re/out_im/out_valid unchanged throughout; bins 0..7 each seen exactly once; in_ready stays 0 until after bin 7.
- SCALE=0, DC frame x[n]=0x7FFF -> bin0 re=0x7FFF (saturated), im=0; other bins 0.
- Reset mid-COMPUTE (rst_n low 2 cycles, cycle 5 of compute) -> out_valid=0, busy=0, in_ready=1 immediately; a following impulse frame produces a correct result.
- N=64 parameter sweep: random frames vs. reference model -> every bin within +/-log2(N) LSB.

Source files
------------

// File: rtl/fantasticfft_fftn.sv
// Iterative in-place radix-2 DIT FFT: loads one frame in bit-reversed order, runs
// log2(N) stages on a single time-shared butterfly, then streams bins out in order.
module fantasticfft_fftn #(
    parameter int N        = 8,
    parameter int WIDTH    = 16,
    parameter int FRAC     = 8,
    parameter int TW_WIDTH = 16,
    parameter int SCALE    = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_re,
    input  logic [WIDTH-1:0] in_im,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_re,
    output logic [WIDTH-1:0] out_im,
    output logic             out_last,
    output logic             busy
);
    localparam int LOG2N = $clog2(N);
    localparam int SW    = $clog2(LOG2N);
    localparam logic signed [WIDTH+1:0] SAT_HI = (WIDTH+2)'(2 ** (WIDTH - 1) - 1);
    localparam logic signed [WIDTH+1:0] SAT_LO = -(WIDTH+2)'(2 ** (WIDTH - 1));

    if ((N < 8) || (N > 256) || ((1 << LOG2N) != N) || (FRAC >= WIDTH)) begin : g_bad_param
        $error("fantasticfft_fftn: unsupported N/FRAC combination");
    end

    typedef enum logic [1:0] {S_LOAD, S_COMPUTE, S_UNLOAD} state_t;
    state_t state, state_nx;

    logic [LOG2N-1:0] idx;
    logic [LOG2N-2:0] bfly;
    logic [SW-1:0]    stage;

    logic signed [WIDTH-1:0]    mem_re [N];
    logic signed [WIDTH-1:0]    mem_im [N];
    logic signed [TW_WIDTH-1:0] tw_re  [N/2];
    logic signed [TW_WIDTH-1:0] tw_im  [N/2];

    // W^k = exp(-j*2*pi*k/N), rounded to nearest, 1.0 = 2^(TW_WIDTH-2).
    function automatic logic signed [TW_WIDTH-1:0] tw_val(input int k, input bit imag);
        real ang, v;
        ang = -2.0 * 3.14159265358979323846 * k / N;
        v   = (imag ? $sin(ang) : $cos(ang)) * (2.0 ** (TW_WIDTH - 2));
        if (v >= 0.0) return TW_WIDTH'($rtoi(v + 0.5));
        else          return TW_WIDTH'(-$rtoi(-v + 0.5));
    endfunction

    for (genvar g = 0; g < N/2; g++) begin : g_tw
        localparam logic signed [TW_WIDTH-1:0] TRE = tw_val(g, 1'b0);
        localparam logic signed [TW_WIDTH-1:0] TIM = tw_val(g, 1'b1);
        assign tw_re[g] = TRE;
        assign tw_im[g] = TIM;
    end

    function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] v);
        logic [LOG2N-1:0] r;
        for (int i = 0; i < LOG2N; i++) r[i] = v[LOG2N-1-i];
        return r;
    endfunction

    function automatic logic signed [WIDTH-1:0] fit(input logic signed [WIDTH+1:0] v);
        if (SCALE != 0)   return WIDTH'(v >>> 1);
        else if (v > SAT_HI) return WIDTH'(SAT_HI);
        else if (v < SAT_LO) return WIDTH'(SAT_LO);
        else              return WIDTH'(v);
    endfunction

    // Butterfly addressing: j splits into group (upper bits) and position in group.
    logic [LOG2N-2:0] pos, grp;
    logic [LOG2N-1:0] addr_a, addr_b;
    logic [LOG2N-2:0] tw_idx;
    always_comb begin
        pos    = bfly & (LOG2N-1)'((1 << stage) - 1);
        grp    = bfly >> stage;
        addr_a = (LOG2N'(grp) << (stage + 1)) | LOG2N'(pos);
        addr_b = addr_a | (LOG2N'(1) << stage);
        tw_idx = (LOG2N-1)'(pos << (LOG2N - 1 - stage));
    end

    logic signed [WIDTH-1:0]          ar, ai, br, bi;
    logic signed [TW_WIDTH-1:0]       wr, wi;
    logic signed [WIDTH+TW_WIDTH:0]   pr, pim;
    logic signed [WIDTH+1:0]          tr, ti;
    logic signed [WIDTH-1:0]          na_re, na_im, nb_re, nb_im;
    always_comb begin
        ar    = mem_re[addr_a];
        ai    = mem_im[addr_a];
        br    = mem_re[addr_b];
        bi    = mem_im[addr_b];
        wr    = tw_re[tw_idx];
        wi    = tw_im[tw_idx];
        pr    = br * wr - bi * wi;
        pim   = br * wi + bi * wr;
        tr    = (WIDTH+2)'(pr >>> (TW_WIDTH - 2));
        ti    = (WIDTH+2)'(pim >>> (TW_WIDTH - 2));
        na_re = fit(ar + tr);
        na_im = fit(ai + ti);
        nb_re = fit(ar - tr);
        nb_im = fit(ai - ti);
    end

    always_ff @(posedge clk) begin
        if (state == S_LOAD && in_valid) begin
            mem_re[bitrev(idx)] <= in_re;
            mem_im[bitrev(idx)] <= in_im;
        end else if (state == S_COMPUTE) begin
            mem_re[addr_a] <= na_re;
            mem_im[addr_a] <= na_im;
            mem_re[addr_b] <= nb_re;
            mem_im[addr_b] <= nb_im;
        end
    end

    // idx wraps to zero at the end of LOAD, so UNLOAD starts at bin 0 for free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx   <= '0;
            bfly  <= '0;
            stage <= '0;
        end else begin
            case (state)
                S_LOAD:    if (in_valid) idx <= idx + 1'b1;
                S_COMPUTE: begin
                    if (bfly == '1) begin
                        bfly  <= '0;
                        stage <= (stage == SW'(LOG2N - 1)) ? '0 : stage + 1'b1;
                    end else begin
                        bfly <= bfly + 1'b1;
                    end
                end
                S_UNLOAD:  if (out_ready) idx <= idx + 1'b1;
                default:   ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_LOAD;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_LOAD:    if (in_valid && idx == LOG2N'(N - 1)) state_nx = S_COMPUTE;
            S_COMPUTE: if (bfly == '1 && stage == SW'(LOG2N - 1)) state_nx = S_UNLOAD;
            S_UNLOAD:  if (out_ready && idx == LOG2N'(N - 1)) state_nx = S_LOAD;
            default:   state_nx = S_LOAD;
        endcase
    end

    // Valid/ready: a sample or bin moves on any rising edge where both are high.
    always_comb begin
        in_ready  = (state == S_LOAD);
        busy      = (state != S_LOAD);
        out_valid = (state == S_UNLOAD);
        out_last  = out_valid && (idx == LOG2N'(N - 1));
        out_re    = out_valid ? mem_re[idx] : '0;
        out_im    = out_valid ? mem_im[idx] : '0;
    end
endmodule

// File: tb/tb_fantasticfft_fftn.sv
// Bench for fantasticfft_fftn: three instances (N=8 scaled, N=8 saturating, N=64 scaled)
// share one stimulus bus selected by sel; expected bins come from a floating-point DFT.
module tb_fantasticfft_fftn;
    localparam int W = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int         sel;
    logic       in_valid, out_ready;
    logic [W-1:0] in_re, in_im;

    logic a_in_ready, a_out_valid, a_out_last, a_busy;
    logic b_in_ready, b_out_valid, b_out_last, b_busy;
    logic c_in_ready, c_out_valid, c_out_last, c_busy;
    logic [W-1:0] a_out_re, a_out_im, b_out_re, b_out_im, c_out_re, c_out_im;

    logic o_in_ready, o_out_valid, o_out_last, o_busy;
    logic [W-1:0] o_out_re, o_out_im;

    fantasticfft_fftn #(.N(8), .WIDTH(W), .FRAC(8), .TW_WIDTH(16), .SCALE(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid && sel == 0), .in_ready(a_in_ready),
        .in_re(in_re), .in_im(in_im), .out_valid(a_out_valid), .out_ready(out_ready && sel == 0),
        .out_re(a_out_re), .out_im(a_out_im), .out_last(a_out_last), .busy(a_busy));

    fantasticfft_fftn #(.N(8), .WIDTH(W), .FRAC(8), .TW_WIDTH(16), .SCALE(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid && sel == 1), .in_ready(b_in_ready),
        .in_re(in_re), .in_im(in_im), .out_valid(b_out_valid), .out_ready(out_ready && sel == 1),
        .out_re(b_out_re), .out_im(b_out_im), .out_last(b_out_last), .busy(b_busy));

    fantasticfft_fftn #(.N(64), .WIDTH(W), .FRAC(8), .TW_WIDTH(16), .SCALE(1)) dut_c (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid && sel == 2), .in_ready(c_in_ready),
        .in_re(in_re), .in_im(in_im), .out_valid(c_out_valid), .out_ready(out_ready && sel == 2),
        .out_re(c_out_re), .out_im(c_out_im), .out_last(c_out_last), .busy(c_busy));

    always_comb begin
        case (sel)
            1: {o_in_ready, o_out_valid, o_out_last, o_busy, o_out_re, o_out_im} =
                   {b_in_ready, b_out_valid, b_out_last, b_busy, b_out_re, b_out_im};
            2: {o_in_ready, o_out_valid, o_out_last, o_busy, o_out_re, o_out_im} =
                   {c_in_ready, c_out_valid, c_out_last, c_busy, c_out_re, c_out_im};
            default: {o_in_ready, o_out_valid, o_out_last, o_busy, o_out_re, o_out_im} =
                   {a_in_ready, a_out_valid, a_out_last, a_busy, a_out_re, a_out_im};
        endcase
    end

    int vectors = 0;
    int miscompares = 0;
    logic [2*W-1:0] exp_q[$];
    int xr[256];
    int xi[256];

    task automatic check_val(input string tag, input int obs, input int exp, input int tol);
        int d;
        vectors++;
        d = obs - exp;
        if (d < 0) d = -d;
        if (d > tol) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (tol %0d) at %0t", tag, obs, exp, tol, $time);
        end
    endtask

    function automatic int round_sat(input real v);
        int r;
        r = (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(-v + 0.5);
        if (r > 32767) r = 32767;
        if (r < -32768) r = -32768;
        return r;
    endfunction

    // Reference DFT, divided by N when the core scales each stage.
    task automatic push_model(input int n, input bit scale);
        real sr, si, ang, div;
        int  er, ei;
        div = scale ? real'(n) : 1.0;
        for (int k = 0; k < n; k++) begin
            sr = 0.0;
            si = 0.0;
            for (int m = 0; m < n; m++) begin
                ang = -2.0 * 3.14159265358979323846 * real'((k * m) % n) / real'(n);
                sr += real'(xr[m]) * $cos(ang) - real'(xi[m]) * $sin(ang);
                si += real'(xr[m]) * $sin(ang) + real'(xi[m]) * $cos(ang);
            end
            er = round_sat(sr / div);
            ei = round_sat(si / div);
            exp_q.push_back({16'(er), 16'(ei)});
        end
    endtask

    task automatic send_frame(input int n);
        int budget;
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            in_valid = 1'b1;
            in_re = 16'(xr[i]);
            in_im = 16'(xi[i]);
            budget = 0;
            while (!o_in_ready && budget < 1000) begin
                @(negedge clk);
                budget++;
            end
            if (budget >= 1000) check_val("load_ready_timeout", 0, 1, 0);
            @(posedge clk);
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    // Counts cycles busy without out_valid; optionally drives junk input that must be ignored.
    task automatic wait_compute(input int n, input bit junk);
        int cnt;
        int c;
        cnt = 0;
        for (c = 0; c < 3000; c++) begin
            if (o_out_valid) break;
            if (junk) begin
                in_valid = 1'b1;
                in_re = 16'($urandom);
                in_im = 16'($urandom);
            end
            if (o_busy && !o_in_ready) cnt++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        check_val("compute_cycles", cnt, $clog2(n) * n / 2, 0);
    endtask

    task automatic receive_frame(input int n, input int tol, input int stall_bin);
        int got;
        int cycles;
        bit stalled;
        logic [2*W-1:0] e;
        got = 0;
        cycles = 0;
        stalled = 1'b0;
        while (got < n && cycles < 5000) begin
            if (got == stall_bin && !stalled && exp_q.size() > 0) begin
                out_ready = 1'b0;
                for (int s = 0; s < 5; s++) begin
                    check_val("stall_valid", int'(o_out_valid), 1, 0);
                    check_val("stall_re", int'($signed(o_out_re)), int'($signed(exp_q[0][31:16])), tol);
                    check_val("stall_im", int'($signed(o_out_im)), int'($signed(exp_q[0][15:0])), tol);
                    check_val("stall_in_ready", int'(o_in_ready), 0, 0);
                    @(negedge clk);
                end
                stalled = 1'b1;
                out_ready = 1'b1;
            end else begin
                out_ready = ($urandom_range(0, 3) != 0);
            end
            check_val("unload_busy_ready", int'({o_busy, o_in_ready}), 2, 0);
            if (o_out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check_val("queue_empty", 1, 0, 0);
                end else begin
                    e = exp_q.pop_front();
                    check_val("bin_re", int'($signed(o_out_re)), int'($signed(e[31:16])), tol);
                    check_val("bin_im", int'($signed(o_out_im)), int'($signed(e[15:0])), tol);
                    check_val("bin_last", int'(o_out_last), int'(got == n - 1), 0);
                end
                got++;
            end
            @(negedge clk);
            cycles++;
        end
        out_ready = 1'b0;
        check_val("unload_count", got, n, 0);
        check_val("post_unload_valid", int'(o_out_valid), 0, 0);
        check_val("post_unload_in_ready", int'(o_in_ready), 1, 0);
    endtask

    task automatic run_frame(input int s, input int n, input bit scale, input int tol,
                             input int stall_bin);
        sel = s;
        @(negedge clk);
        push_model(n, scale);
        send_frame(n);
        wait_compute(n, 1'b1);
        receive_frame(n, tol, stall_bin);
    endtask

    task automatic check_idle(input string tag);
        check_val(tag, int'({o_in_ready, o_out_valid, o_out_last, o_busy}), 8, 0);
        check_val({tag, "_data"}, int'({o_out_re, o_out_im}), 0, 0);
    endtask

    task automatic set_impulse(input int n);
        for (int i = 0; i < n; i++) begin
            xr[i] = (i == 0) ? 256 : 0;
            xi[i] = 0;
        end
    endtask

    initial begin
        sel = 0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        in_re = '0;
        in_im = '0;
        repeat (3) @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1 check_idle("reset_state");
        end
        rst_n = 1'b1;
        @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1 check_idle("after_reset");
        end

        set_impulse(8);
        run_frame(0, 8, 1'b1, 0, -1);

        for (int i = 0; i < 8; i++) begin xr[i] = 256; xi[i] = 0; end
        run_frame(0, 8, 1'b1, 1, -1);

        for (int i = 0; i < 8; i++) begin xr[i] = (i % 2 == 0) ? 256 : -256; xi[i] = 0; end
        run_frame(0, 8, 1'b1, 1, -1);

        set_impulse(8);
        run_frame(0, 8, 1'b1, 0, 3);

        for (int i = 0; i < 8; i++) begin xr[i] = 32767; xi[i] = 0; end
        run_frame(1, 8, 1'b0, 0, -1);

        // Abort a frame five cycles into COMPUTE; nothing is expected from it.
        sel = 0;
        set_impulse(8);
        @(negedge clk);
        send_frame(8);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1 check_idle("reset_mid_compute");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1 check_idle("after_abort");
        set_impulse(8);
        run_frame(0, 8, 1'b1, 0, -1);

        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < 64; i++) begin
                xr[i] = $urandom_range(0, 2048) - 1024;
                xi[i] = $urandom_range(0, 2048) - 1024;
            end
            run_frame(2, 64, 1'b1, 6, (f == 1) ? 17 : -1);
        end

        check_val("queue_drained", exp_q.size(), 0, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog");
    end
endmodule
